// File: rtl/sca_feature_scheduler_pkg.sv
// sca_pkg: shared Q3.7 constants, FSM state type and saturation helper
package sca_pkg;
  localparam int Q_W = 10;
  localparam int FRAC_BITS = 7;
  localparam int HD_W = 8;
  localparam logic [Q_W-1:0] Q_MAX = 10'd1023;
  typedef enum logic [2:0] {IDLE, ACCUM, PRESENT, SETTLE, REPORT} state_e;
  function automatic logic [Q_W-1:0] sat_q37(input logic [31:0] x);
    return x > 32'(Q_MAX) ? Q_MAX : x[Q_W-1:0];
  endfunction
endpackage

// File: rtl/sca_feature_scheduler_if.sv
// sca_feature_scheduler_if: sample stream, detector features and verdict handshake
interface sca_feature_scheduler_if;
  import sca_pkg::*;
  logic s_valid;
  logic s_ready;
  logic [Q_W-1:0] s_sample;
  logic [HD_W-1:0] s_hd;
  logic [Q_W-1:0] det_energy;
  logic [Q_W-1:0] det_peak;
  logic [Q_W-1:0] det_mean;
  logic [HD_W-1:0] det_hd;
  logic det_attack;
  logic v_valid;
  logic v_ready;
  logic v_attack;
  logic [7:0] v_window_id;
  modport slave (
    input s_valid, s_sample, s_hd, det_attack, v_ready,
    output s_ready, det_energy, det_peak, det_mean, det_hd, v_valid, v_attack, v_window_id
  );
  modport master (
    output s_valid, s_sample, s_hd, det_attack, v_ready,
    input s_ready, det_energy, det_peak, det_mean, det_hd, v_valid, v_attack, v_window_id
  );
endinterface

// File: rtl/sca_feature_scheduler_accum.sv
// sca_window_accum: per-window sum, square-sum, peak and sample count
module sca_window_accum import sca_pkg::*; #(
  parameter int LOG2_WIN = 3,
  localparam int SUM_W = Q_W + LOG2_WIN,
  localparam int SQ_W = 2 * Q_W + LOG2_WIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             accept_i,
  input  logic [Q_W-1:0]   sample_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [SQ_W-1:0]  sq_o,
  output logic [Q_W-1:0]   max_o,
  output logic             last_o
);
  logic [SUM_W-1:0] sum_q;
  logic [SQ_W-1:0] sq_q;
  logic [Q_W-1:0] max_q;
  logic [LOG2_WIN:0] cnt_q;
  logic [2*Q_W-1:0] sq_s;
  assign sq_s = {{Q_W{1'b0}}, sample_i} * {{Q_W{1'b0}}, sample_i};
  // high when the next accepted sample completes the window
  assign last_o = cnt_q == (LOG2_WIN+1)'((1 << LOG2_WIN) - 1);
  assign sum_o = sum_q;
  assign sq_o = sq_q;
  assign max_o = max_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q <= '0;
      sq_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      sum_q <= SUM_W'(sample_i);
      sq_q <= SQ_W'(sq_s);
      max_q <= sample_i;
      cnt_q <= (LOG2_WIN+1)'(1);
    end else if (accept_i) begin
      sum_q <= sum_q + SUM_W'(sample_i);
      sq_q <= sq_q + SQ_W'(sq_s);
      max_q <= sample_i > max_q ? sample_i : max_q;
      cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/sca_feature_scheduler.sv
// sca_feature_scheduler: windowed feature extraction and verdict sequencing for the attack detector
module sca_feature_scheduler import sca_pkg::*; #(
  parameter int LOG2_WIN = 3,
  parameter int SETTLE_CYC = 4,
  parameter int FRAC_BITS = sca_pkg::FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sca_feature_scheduler_if.slave      bus,
  output logic [7:0]                  attack_cnt_o,
  output logic                        busy_o
);
  state_e state_q;
  logic s_ready_q, v_valid_q, v_attack_q;
  logic [HD_W-1:0] hd_q, det_hd_q;
  logic [Q_W-1:0] det_energy_q, det_peak_q, det_mean_q;
  logic [7:0] wid_q, v_wid_q, attack_cnt_q, settle_q;
  logic [Q_W+LOG2_WIN-1:0] sum_w;
  logic [2*Q_W+LOG2_WIN-1:0] sq_w;
  logic [Q_W-1:0] max_w;
  logic xfer, last_w;
  assign xfer = bus.s_valid & s_ready_q;
  sca_window_accum #(.LOG2_WIN(LOG2_WIN)) u_accum (
    .clk(clk), .rst_n(rst_n),
    .start_i(xfer && state_q == IDLE), .accept_i(xfer && state_q == ACCUM),
    .sample_i(bus.s_sample),
    .sum_o(sum_w), .sq_o(sq_w), .max_o(max_w), .last_o(last_w)
  );
  assign bus.s_ready = s_ready_q;
  assign bus.det_energy = det_energy_q;
  assign bus.det_peak = det_peak_q;
  assign bus.det_mean = det_mean_q;
  assign bus.det_hd = det_hd_q;
  assign bus.v_valid = v_valid_q;
  assign bus.v_attack = v_attack_q;
  assign bus.v_window_id = v_wid_q;
  assign attack_cnt_o = attack_cnt_q;
  assign busy_o = state_q != IDLE;
  // s_ready is registered so it stays low through reset and rises one clock after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      s_ready_q <= 1'b0;
      v_valid_q <= 1'b0;
      v_attack_q <= 1'b0;
      hd_q <= '0;
      det_hd_q <= '0;
      det_energy_q <= '0;
      det_peak_q <= '0;
      det_mean_q <= '0;
      wid_q <= '0;
      v_wid_q <= '0;
      attack_cnt_q <= '0;
      settle_q <= '0;
    end else
      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (xfer) begin
            hd_q <= bus.s_hd;
            state_q <= ACCUM;
          end
        end
        ACCUM:
          if (xfer && last_w) begin
            s_ready_q <= 1'b0;
            state_q <= PRESENT;
          end
        PRESENT: begin
          det_energy_q <= sat_q37(32'(sq_w >> FRAC_BITS));
          det_mean_q <= sum_w[LOG2_WIN +: Q_W];
          det_peak_q <= max_w;
          det_hd_q <= hd_q;
          settle_q <= '0;
          state_q <= SETTLE;
        end
        SETTLE:
          if (settle_q == 8'(SETTLE_CYC - 1)) begin
            v_attack_q <= bus.det_attack;
            v_wid_q <= wid_q;
            v_valid_q <= 1'b1;
            state_q <= REPORT;
          end else
            settle_q <= settle_q + 1'b1;
        REPORT:
          if (bus.v_ready) begin
            v_valid_q <= 1'b0;
            wid_q <= wid_q + 1'b1;
            if (v_attack_q && attack_cnt_q != 8'hff) attack_cnt_q <= attack_cnt_q + 1'b1;
            s_ready_q <= 1'b1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_sca_feature_scheduler.sv
// tb_sca_feature_scheduler: directed windows with a verdict scoreboard and monitor
module tb_sca_feature_scheduler;
  typedef struct {
    logic att;
    logic [7:0] wid;
    logic [9:0] en, pk, mn;
    logic [7:0] hd;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] attack_cnt;
  logic busy;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  exp_t e;
  logic [9:0] win_s [8];
  sca_feature_scheduler_if bus();
  sca_feature_scheduler #(.LOG2_WIN(3), .SETTLE_CYC(4), .FRAC_BITS(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .attack_cnt_o(attack_cnt), .busy_o(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.v_valid && bus.v_ready) begin
      if (sbq.size() == 0) chk("unexpected_verdict", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("v_attack", 32'(bus.v_attack), 32'(e.att));
        chk("v_window_id", 32'(bus.v_window_id), 32'(e.wid));
        chk("det_energy", 32'(bus.det_energy), 32'(e.en));
        chk("det_peak", 32'(bus.det_peak), 32'(e.pk));
        chk("det_mean", 32'(bus.det_mean), 32'(e.mn));
        chk("det_hd", 32'(bus.det_hd), 32'(e.hd));
      end
    end
  task automatic send(input logic [9:0] s, input logic [7:0] hd);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_sample = s;
    bus.s_hd = hd;
    @(negedge clk);
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask
  task automatic window(input logic [7:0] hd, input logic att, input logic [7:0] wid,
                        input logic [9:0] en, input logic [9:0] pk, input logic [9:0] mn);
    int n = 0;
    bus.det_attack = att;
    sbq.push_back('{att, wid, en, pk, mn, hd});
    for (int i = 0; i < 8; i++) send(win_s[i], hd);
    while (!bus.v_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("verdict_latency", 32'(n), 5);
  endtask
  task automatic drain();
    int n = 0;
    while (bus.v_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 50) chk("handshake_timeout", 0, 1);
  endtask
  task automatic fill(input logic [9:0] v);
    for (int i = 0; i < 8; i++) win_s[i] = v;
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_sample = '0;
    bus.s_hd = '0;
    bus.det_attack = 1'b0;
    bus.v_ready = 1'b1;
    #3;
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_v_valid", 32'(bus.v_valid), 0);
    chk("rst_det_energy", 32'(bus.det_energy), 0);
    chk("rst_attack_cnt", 32'(attack_cnt), 0);
    #19 rst_n = 1'b1;
    #1 chk("s_ready_before_clock", 32'(bus.s_ready), 0);
    @(posedge clk);
    #1 chk("s_ready_after_clock", 32'(bus.s_ready), 1);
    fill(10'd10);
    window(8'd0, 1'b0, 8'd0, 10'd6, 10'd10, 10'd10);
    drain();
    chk("cnt_after_w0", 32'(attack_cnt), 0);
    win_s = '{10'd7, 10'd7, 10'd7, 10'd20, 10'd7, 10'd7, 10'd7, 10'd7};
    window(8'd7, 1'b1, 8'd1, 10'd5, 10'd20, 10'd8);
    drain();
    chk("cnt_after_w1", 32'(attack_cnt), 1);
    fill(10'd1023);
    window(8'd3, 1'b0, 8'd2, 10'd1023, 10'd1023, 10'd1023);
    drain();
    chk("cnt_after_w2", 32'(attack_cnt), 1);
    bus.v_ready = 1'b0;
    fill(10'd10);
    window(8'd5, 1'b1, 8'd3, 10'd6, 10'd10, 10'd10);
    bus.det_attack = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_sample = 10'd999;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_v_valid", 32'(bus.v_valid), 1);
      chk("hold_v_attack", 32'(bus.v_attack), 1);
      chk("hold_v_window_id", 32'(bus.v_window_id), 3);
      chk("hold_s_ready", 32'(bus.s_ready), 0);
    end
    chk("hold_pending", 32'(sbq.size()), 1);
    bus.v_ready = 1'b1;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    chk("release_v_valid", 32'(bus.v_valid), 0);
    chk("release_s_ready", 32'(bus.s_ready), 1);
    chk("release_pending", 32'(sbq.size()), 0);
    chk("cnt_after_hold", 32'(attack_cnt), 2);
    win_s = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8};
    window(8'd9, 1'b0, 8'd4, 10'd1, 10'd8, 10'd4);
    drain();
    fill(10'd10);
    for (int i = 0; i < 5; i++) send(10'd10, 8'd2);
    chk("partial_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_s_ready", 32'(bus.s_ready), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_det_mean", 32'(bus.det_mean), 0);
    chk("async_det_hd", 32'(bus.det_hd), 0);
    chk("async_window_id", 32'(bus.v_window_id), 0);
    chk("async_attack_cnt", 32'(attack_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      window(8'd0, 1'b1, 8'(i), 10'd6, 10'd10, 10'd10);
      drain();
      chk("sat_attack_cnt", 32'(attack_cnt), (i + 1 > 255) ? 255 : i + 1);
    end
    chk("final_window_id", 32'(bus.v_window_id), 3);
    chk("final_pending", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sca_feature_scheduler.md
Name: sca_feature_scheduler

Overview:
- Windowed front end and sequencer for fuzzy_attack_fsm.
- Consumes a stream of Q3.7 power samples plus a per-trace Hamming distance, and computes energy, peak and mean features over a fixed window.
- Presents the features to the detector, holds them stable for a settle period, then captures attack_detected.
- Hands each verdict downstream on a valid/ready interface and keeps a saturating attack counter.

Parameters:
- LOG2_WIN, 3: log2 of samples per window (WIN = 2^LOG2_WIN). Legal range 1..6.
- SETTLE_CYC, 4: cycles det_* are held stable before det_attack is sampled. Minimum 1.
- FRAC_BITS, 7: fractional bits of the Q3.7 format, used to rescale the sum of squares.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  sample valid.
- s_ready  out  1  scheduler accepts a sample this cycle.
- s_sample  in  10  power sample, unsigned Q3.7.
- s_hd  in  8  Hamming distance of the trace; latched with the first sample of a window.
- det_energy  out  10  feature to detector, Q3.7.
- det_peak  out  10  feature to detector, Q3.7.
- det_mean  out  10  feature to detector, Q3.7.
- det_hd  out  8  latched Hamming distance.
- det_attack  in  1  attack_detected from the detector.
- v_valid  out  1  verdict valid.
- v_ready  in  1  downstream accepts the verdict.
- v_attack  out  1  captured verdict.
- v_window_id  out  8  index of the window this verdict belongs to; wraps 255->0.
- attack_cnt  out  8  count of attack verdicts delivered, saturating at 255.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; every output and accumulator is 0; window id=0. s_ready becomes 1 on the first clock after release.
- A transfer occurs when s_valid & s_ready. s_ready=1 only in IDLE and ACCUM.
- IDLE: on a transfer, latch s_hd and initialise the accumulators (sum=s, sq=s*s, max=s, cnt=1); go to ACCUM.
- ACCUM: on each transfer, sum+=s, sq+=s*s, max=max(max,s), cnt++. The transfer that makes cnt==WIN moves the FSM to PRESENT. Cycles without a transfer hold all state.
- Accumulator widths:
  - sum: 10+LOG2_WIN bits.
  - sq: 20+LOG2_WIN bits.
  - Neither can overflow.
- PRESENT (1 cycle): register the features onto det_*:
  - det_energy = min(sq >> FRAC_BITS, 1023).
  - det_mean = sum >> LOG2_WIN (truncate).
  - det_peak = max.
  - det_hd = the latched hd.
  - Then go to SETTLE with settle counter = 0.
- Between windows det_* hold their last values; they change only in PRESENT.
- Latency: the last sample is accepted at edge T. det_* are updated at edge T+1.
- SETTLE: runs for SETTLE_CYC cycles after PRESENT. On its final edge (T+1+SETTLE_CYC):
  - v_attack is captured from det_attack.
  - v_window_id = current window id.
  - v_valid is set.
  - The FSM goes to REPORT.
- REPORT: v_valid, v_attack and v_window_id are held stable until v_ready.
  - On the handshake edge: v_valid=0; window id increments (wraps); attack_cnt increments if v_attack=1 (saturates at 255); go to IDLE.
  - v_ready while v_valid=0 is ignored.
- Backpressure: no samples are accepted in PRESENT, SETTLE or REPORT, so upstream stalls.
- s_valid with s_ready=0 has no effect.
- Reset mid-operation clears the partial window, counters, id and verdict. There is no residual state.

Decomposition:
- Shared package sca_pkg:
  - Q3.7 constants: Q_W=10, FRAC_BITS=7, Q_MAX=10'd1023.
  - HD_W=8.
  - State enum {IDLE, ACCUM, PRESENT, SETTLE, REPORT}.
  - Helper function sat_q37 (clamp to Q_MAX).
- One natural sub-module: sca_window_accum, holding the sum, square-sum, max and count registers plus the cnt==WIN flag, driven by a start/accept pulse.
- The FSM, settle counter, verdict register and attack counter stay in the top module.

Test Plan (LOG2_WIN=3, SETTLE_CYC=4):
- 8 samples of 10, s_hd=0, det_attack=0:
  - det_energy=6 (800>>7), det_peak=10, det_mean=10, det_hd=0.
  - v_valid rises 5 cycles after the last accept, with v_attack=0 and v_window_id=0.
  - attack_cnt stays 0.
- Samples {7,7,7,20,7,7,7,7}, s_hd=7, det_attack=1:
  - det_energy=5 (743>>7), det_peak=20, det_mean=8, det_hd=7.
  - v_attack=1, v_window_id=1.
  - attack_cnt=1 after the handshake.
- 8 samples of 1023:
  - det_energy=1023 (saturated), det_peak=1023, det_mean=1023.
- Hold v_ready=0 for 10 cycles in REPORT:
  - v_valid and v_attack stay stable and s_ready=0.
  - No samples are consumed despite s_valid=1.
  - After v_ready=1, exactly one handshake occurs, then s_ready=1.
- Assert rst_n=0 asynchronously after 5 of 8 samples:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a full 8-sample window of 10 gives det_mean=10 and v_window_id=0.
- Run 260 attack windows with v_ready=1:
  - attack_cnt saturates at 255.
  - v_window_id wraps past 255 to 0 and continues to 3.
